// File: rtl/rr_merge_mux_pkg.sv
// Shared definitions for the round-robin merge multiplexer: arbitration mode
// encodings and the sizing helpers used by the top level and its FIFOs.
package rr_merge_mux_pkg;

   typedef enum int {
      RR_MODE_FIXED       = 0,
      RR_MODE_ROUND_ROBIN = 1
   } rr_mode_e;

   // Ceiling log2, never below 1 so that index ports always have a bit.
   function automatic int clog2(input int value);
      int result;
      result = 1;
      while ((1 << result) < value) result++;
      return result;
   endfunction

   function automatic int fifo_depth(input int log_len);
      return 1 << log_len;
   endfunction

endpackage

// File: rtl/rr_merge_mux_sync_fifo.sv
// First-word-fall-through FIFO with a registered occupancy count; a word
// written on one edge becomes visible at dout only after that edge.
module sync_fifo
   import rr_merge_mux_pkg::*;
#(
   parameter int bit_width = 15,
   parameter int addr_len  = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  logic [bit_width-1:0] din,
   output logic [bit_width-1:0] dout,
   output logic                 full,
   output logic                 empty
);

   localparam int depth = fifo_depth(addr_len);
   localparam logic [addr_len:0] count_full = (addr_len + 1)'(depth);
   localparam logic [addr_len:0] count_one  = (addr_len + 1)'(1);
   localparam logic [addr_len-1:0] ptr_one  = addr_len'(1);

   logic [bit_width-1:0] mem [depth];
   logic [addr_len-1:0]  wr_ptr;
   logic [addr_len-1:0]  rd_ptr;
   logic [addr_len:0]    count;
   logic                 do_push;
   logic                 do_pop;

   assign full    = (count == count_full);
   assign empty   = (count == '0);
   // A full FIFO refuses a push even if it is popped on the same edge.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // NOTE: the storage array is deliberately not reset; count and pointers
   // alone decide which entries are live, and an unreset array can map to RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + ptr_one;
         if (do_pop)  rd_ptr <= rd_ptr + ptr_one;
         case ({do_push, do_pop})
            2'b10:   count <= count + count_one;
            2'b01:   count <= count - count_one;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rr_merge_mux.sv
// Merges n_inputs valid-tagged word streams through per-channel FIFOs into a
// single registered output, arbitrating round-robin or by fixed priority.
module rr_merge_mux
   import rr_merge_mux_pkg::*;
#(
   parameter int word_width     = 16,
   parameter int val_bit        = 1,
   parameter int log_buffer_len = 3,
   parameter int n_inputs       = 4,
   parameter int rr_mode        = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             busy,
   input  logic [n_inputs*word_width-1:0]   in,
   output logic [word_width-1:0]            out,
   output logic [clog2(n_inputs)-1:0]       src,
   output logic [n_inputs-1:0]              full,
   output logic [n_inputs-1:0]              ovf
);

   localparam int data_width = word_width - val_bit;
   localparam int src_width  = clog2(n_inputs);
   localparam bit use_rr     = (rr_mode == int'(RR_MODE_ROUND_ROBIN));

   typedef logic [src_width-1:0] idx_t;

   logic [n_inputs-1:0]   in_valid;
   logic [n_inputs-1:0]   fifo_full;
   logic [n_inputs-1:0]   fifo_empty;
   logic [n_inputs-1:0]   pop;
   logic [data_width-1:0] fifo_dout [n_inputs];

   idx_t                  prio_ptr;
   idx_t                  grant;
   logic                  grant_valid;
   logic                  out_valid;
   logic [data_width-1:0] out_data;

   for (genvar i = 0; i < n_inputs; i++) begin : g_chan
      assign in_valid[i] = in[i*word_width + word_width - 1];

      sync_fifo #(
         .bit_width (data_width),
         .addr_len  (log_buffer_len)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (in_valid[i]),
         .pop   (pop[i]),
         .din   (in[i*word_width +: data_width]),
         .dout  (fifo_dout[i]),
         .full  (fifo_full[i]),
         .empty (fifo_empty[i])
      );
   end

   assign full = fifo_full | {n_inputs{busy}};

   // Search upward from the priority pointer (or from 0 in fixed mode), wrapping.
   always_comb begin
      int idx;
      // NOTE: every combinational output gets a default before any branch,
      // so no path leaves a variable unassigned and no latch is inferred.
      grant       = '0;
      grant_valid = 1'b0;
      idx         = 0;
      for (int k = 0; k < n_inputs; k++) begin
         idx = use_rr ? int'(prio_ptr) + k : k;
         if (idx >= n_inputs) idx = idx - n_inputs;
         if (!grant_valid && !fifo_empty[idx]) begin
            grant_valid = 1'b1;
            grant       = idx_t'(idx);
         end
      end
   end

   always_comb begin
      pop = '0;
      if (grant_valid && !busy) pop[grant] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         src       <= '0;
         prio_ptr  <= '0;
         ovf       <= '0;
      end else begin
         out_valid <= |pop;
         if (|pop) begin
            out_data <= fifo_dout[grant];
            src      <= grant;
            if (use_rr)
               prio_ptr <= (grant == idx_t'(n_inputs - 1)) ? '0 : grant + idx_t'(1);
         end
         ovf <= ovf | (in_valid & fifo_full);
      end
   end

   // Valid flag on the MSB, data in the low bits, any extra validity bits zero.
   always_comb begin
      out                   = '0;
      out[word_width-1]     = out_valid;
      out[data_width-1:0]   = out_data;
   end

endmodule
